// File: rtl/apb_wait_regfile.sv
// APB slave register file with a fixed number of wait states per access.
// Word 0 is a read-only ID word. Words 1..DEPTH-1 are byte-writable storage.
// Illegal accesses complete with PSLVERR: a misaligned address, an
// out-of-range address, or a write to word 0.
//
// state  | meaning
// IDLE   | no transfer in flight; setup phase captured here
// ACCESS | access phase; cnt counts down the remaining wait states
module apb_wait_regfile #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA5B2_0001
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic IDLE   = 1'b0;
    localparam logic ACCESS = 1'b1;

    logic                    state;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] strb_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [IDX_W-1:0]        idx;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    err;
    logic                    ready_acc;
    logic                    complete;
    logic [DATA_WIDTH-1:0]   rd_word;

    // Decode works purely from the address and direction latched at setup.
    always_comb begin
        idx          = addr_q[IDX_W+1:2];
        misaligned   = |addr_q[1:0];
        out_of_range = (addr_q >> (IDX_W + 2)) != '0;
        err          = misaligned || out_of_range || (write_q && (idx == '0));
        ready_acc    = (state == ACCESS) && (cnt == 4'd0);
        complete     = ready_acc && PSEL && PENABLE;
        rd_word      = (idx == '0) ? ID_VALUE : mem[idx];
    end

    // Outputs come from registered state only; PREADY idles high outside ACCESS.
    always_comb begin
        PREADY  = (state == IDLE) || (cnt == 4'd0);
        PSLVERR = ready_acc && err;
        PRDATA  = (ready_acc && !err && !write_q) ? rd_word : '0;
    end

    // Transfer FSM: setup capture, wait-state countdown, completion and abort.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A select with PENABLE already high skipped its setup phase.
                    if (PSEL && !PENABLE) begin
                        addr_q  <= PADDR;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                        strb_q  <= PSTRB;
                        cnt     <= 4'(WAIT_STATES);
                        state   <= ACCESS;
                    end
                end
                default: begin
                    if (!PSEL) begin
                        state <= IDLE;
                    end else if (complete) begin
                        state <= IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    // Storage: byte-lane write on a legal completing write; cleared by reset.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else if (complete && write_q && !err) begin
            for (int i = 0; i < DATA_WIDTH/8; i++) begin
                if (strb_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_wait_regfile.sv
// Directed bench for apb_wait_regfile. Instance 0 uses two wait states,
// instance 1 uses none. The driver pushes expected responses into a per-instance
// queue; a monitor on the falling clock edge pops them at each completing
// cycle and checks PSLVERR, the wait-state count and read data.
module tb_apb_wait_regfile;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
        int          waits;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  psel, penable, pwrite, pready, pslverr;
    logic [31:0] paddr  [2];
    logic [31:0] pwdata [2];
    logic [3:0]  pstrb  [2];
    logic [31:0] prdata [2];

    exp_t q0 [$];
    exp_t q1 [$];
    int   waits [2];
    int   total = 0;
    int   bad   = 0;

    apb_wait_regfile #(.WAIT_STATES(2)) dut0 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb_wait_regfile #(.WAIT_STATES(0)) dut1 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: count wait cycles and score every completing access cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst || !psel[k]) begin
                waits[k] = 0;
            end else if (penable[k] && !pready[k]) begin
                waits[k]++;
            end else if (penable[k] && pready[k]) begin
                exp_t e;
                logic got;
                got = 1'b0;
                if (k == 0 && q0.size() > 0) begin
                    e = q0.pop_front();
                    got = 1'b1;
                end else if (k == 1 && q1.size() > 0) begin
                    e = q1.pop_front();
                    got = 1'b1;
                end
                if (!got) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_completion: dut%0d completed with no expectation", k);
                end else begin
                    check($sformatf("pslverr dut%0d", k), {31'd0, pslverr[k]}, {31'd0, e.err});
                    check($sformatf("waits dut%0d", k), 32'(waits[k]), 32'(e.waits));
                    if (e.chk_rd)
                        check($sformatf("prdata dut%0d", k), prdata[k], e.rdata);
                end
                waits[k] = 0;
            end
        end
    end

    task automatic bus_idle(input int k);
        psel[k] = 1'b0;
        penable[k] = 1'b0;
    endtask

    // One APB transfer; PADDR/PWDATA/PSTRB are scrambled during the access
    // phase, which must not affect the result. Leaves the bus driven so a
    // following call runs back to back.
    task automatic apb(input int k, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        logic done;
        e.rdata  = exp_rd;
        e.err    = exp_err;
        e.chk_rd = !wr;
        e.waits  = (k == 0) ? 2 : 0;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        psel[k] = 1'b1;
        penable[k] = 1'b0;
        pwrite[k] = wr;
        paddr[k] = addr;
        pwdata[k] = wdata;
        pstrb[k] = strb;
        @(posedge clk); #1;
        penable[k] = 1'b1;
        paddr[k] = ~addr;
        pwdata[k] = ~wdata;
        pstrb[k] = ~strb;
        done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (pready[k]) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout: dut%0d PREADY never rose for addr %h", k, addr);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus_idle(k);
            pwrite[k] = 1'b0;
            paddr[k] = '0;
            pwdata[k] = '0;
            pstrb[k] = '0;
            waits[k] = 0;
        end
        #2;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_pready dut%0d", k), {31'd0, pready[k]}, 32'd1);
            check($sformatf("rst_prdata dut%0d", k), prdata[k], 32'd0);
            check($sformatf("rst_pslverr dut%0d", k), {31'd0, pslverr[k]}, 32'd0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_pready", {31'd0, pready[0]}, 32'd1);

        // ID word and byte strobes
        apb(0, 0, 32'h00, 0, 0, 32'hA5B2_0001, 0);
        apb(0, 1, 32'h08, 32'h1234_5678, 4'b1111, 0, 0);
        apb(0, 1, 32'h08, 32'hFFFF_FFFF, 4'b0101, 0, 0);
        apb(0, 0, 32'h08, 0, 0, 32'h12FF_56FF, 0);
        // Error cases
        apb(0, 1, 32'h00, 32'h1111_1111, 4'b1111, 0, 1);
        apb(0, 1, 32'h06, 32'h2222_2222, 4'b1111, 0, 1);
        apb(0, 1, 32'h40, 32'h3333_3333, 4'b1111, 0, 1);
        apb(0, 0, 32'h00, 0, 0, 32'hA5B2_0001, 0);
        apb(0, 0, 32'h40, 0, 0, 32'h0, 1);
        apb(0, 0, 32'h02, 0, 0, 32'h0, 1);
        apb(0, 0, 32'h04, 0, 0, 32'h0, 0);
        // Last word, and a write with no strobes
        apb(0, 1, 32'h3C, 32'h0BAD_F00D, 4'b1111, 0, 0);
        apb(0, 0, 32'h3C, 0, 0, 32'h0BAD_F00D, 0);
        apb(0, 1, 32'h10, 32'hCAFE_F00D, 4'b1111, 0, 0);
        apb(0, 1, 32'h10, 32'h1111_1111, 4'b0000, 0, 0);
        apb(0, 0, 32'h10, 0, 0, 32'hCAFE_F00D, 0);
        bus_idle(0);
        @(posedge clk); #1;

        // Abort: drop PSEL after the first wait cycle
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'h04; pwdata[0] = 32'hDEAD_BEEF; pstrb[0] = 4'b1111;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        @(posedge clk); #1;
        bus_idle(0);
        @(posedge clk); #1;
        apb(0, 0, 32'h04, 0, 0, 32'h0, 0);
        bus_idle(0);
        @(posedge clk); #1;

        // Reset during the second wait cycle of a write
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'h0C; pwdata[0] = 32'h5555_AAAA; pstrb[0] = 4'b1111;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_pready", {31'd0, pready[0]}, 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_pready", {31'd0, pready[0]}, 32'd1);
        check("midrst_prdata", prdata[0], 32'd0);
        check("midrst_pslverr", {31'd0, pslverr[0]}, 32'd0);
        bus_idle(0);
        @(posedge clk); #1;
        rst = 1'b0;
        apb(0, 0, 32'h0C, 0, 0, 32'h0, 0);
        apb(0, 0, 32'h08, 0, 0, 32'h0, 0);
        bus_idle(0);

        // Zero wait states, back to back
        apb(1, 1, 32'h04, 32'd1, 4'b1111, 0, 0);
        apb(1, 1, 32'h08, 32'd2, 4'b1111, 0, 0);
        apb(1, 0, 32'h04, 0, 0, 32'd1, 0);
        apb(1, 0, 32'h08, 0, 0, 32'd2, 0);
        bus_idle(1);

        repeat (3) @(posedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
